// File: rtl/frv_pipeline_fifo_register.sv
// Elastic pipeline stage register: DEPTH-entry FIFO with valid/busy
// handshakes, registered outputs, flush and most-recent-data tracking.
module frv_pipeline_fifo_register #(
    parameter  int RLEN  = 8,
    parameter  int DEPTH = 2,
    localparam int CLEN  = $clog2(DEPTH + 1)
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic [RLEN-1:0] i_data,
    input  logic            i_valid,
    output logic            o_busy,
    output logic [RLEN-1:0] mr_data,
    input  logic            flush,
    input  logic [RLEN-1:0] flush_dat,
    output logic [RLEN-1:0] o_data,
    output logic            o_valid,
    input  logic            i_busy,
    output logic [CLEN-1:0] o_count
);

    localparam int              PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   PLAST = PW'(DEPTH - 1);
    localparam logic [CLEN-1:0] CFULL = CLEN'(DEPTH);

    logic [RLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [CLEN-1:0] count_q, count_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic [RLEN-1:0] data_q, data_d;
    logic [RLEN-1:0] mr_q, mr_d;
    logic            push;
    logic            pop;
    logic [CLEN-1:0] kept;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PLAST) ? '0 : p + PW'(1);
    endfunction

    // Qualify handshakes and compute the next queue state and head.
    always_comb begin
        push    = i_valid && !busy_q && !flush;
        pop     = valid_q && !i_busy && !flush;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        data_d  = data_q;
        mr_d    = mr_q;
        kept    = count_q - CLEN'(pop);
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            data_d  = flush_dat;
            mr_d    = flush_dat;
        end else begin
            if (pop) begin
                rptr_d = ptr_inc(rptr_q);
            end
            if (push) begin
                wptr_d = ptr_inc(wptr_q);
                mr_d   = i_data;
            end
            count_d = kept + CLEN'(push);
            // An emptied queue forwards the new entry; else the next held one.
            if (kept == '0) begin
                if (push) begin
                    data_d = i_data;
                end
            end else begin
                data_d = mem_q[rptr_d];
            end
            valid_d = (count_d != '0);
            busy_d  = (count_d == CFULL);
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            mr_q    <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            mr_q    <= mr_d;
        end
    end

    // Entry storage; contents are qualified by the count, so no reset.
    always_ff @(posedge g_clk) begin
        if (g_resetn && push) begin
            mem_q[wptr_q] <= i_data;
        end
    end

    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign mr_data = mr_q;
    assign o_count = count_q;

endmodule
